// File: rtl/bsg_mem_1rw_arb_pkg.sv
// Shared types and helpers for the 1RW bit-masked memory arbiter.
//   bsg_mem_1rw_arb_state_e : sequencer state (eInit clear sweep, eReady serving)
//   safe_clog2              : ceil(log2(n)), at least 1
package bsg_mem_1rw_arb_pkg;

  typedef enum logic {
    eInit  = 1'b0,
    eReady = 1'b1
  } bsg_mem_1rw_arb_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_arb_rr.sv
// Round-robin one-hot arbiter with a registered priority pointer.
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   en         : arbitration enable; when low no grant is issued
//   eligible   : per-requester eligibility
//   grant      : one-hot (or zero) grant, combinational
module bsg_mem_1rw_arb_rr
  import bsg_mem_1rw_arb_pkg::*;
#(
  parameter int unsigned num_req_p = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [num_req_p-1:0] eligible,
  output logic [num_req_p-1:0] grant
);

  localparam int unsigned ptr_w = safe_clog2(num_req_p);

  logic [ptr_w-1:0] ptr;
  logic [ptr_w-1:0] ptr_next;
  logic [ptr_w-1:0] idx;
  logic [ptr_w-1:0] winner;
  logic             found;

  // Scan from the pointer upward; first eligible requester wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = ptr_w'((32'(ptr) + k) % num_req_p);
      if (en && !found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
    ptr_next = ptr;
    if (found) begin
      ptr_next = (32'(winner) == num_req_p - 1) ? '0 : ptr_w'(winner + ptr_w'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Shares one 1RW synchronous bit-masked-write memory among num_req_p
// requesters: round-robin grant, 1-cycle read return with per-requester
// hold register (valid/yumi), optional zero-fill sweep after reset.
// Optional feature macro: BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN (clear sweep).
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   v_i, w_i, addr_i, data_i, w_mask_i   per-requester request
//   ready_o                        one-hot grant (combinational)
//   v_o, data_o, yumi_i            per-requester read response handshake
//   init_done_o                    memory available
//   mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, mem_data_i
//                                  memory port
module bsg_mem_1rw_sync_mask_write_bit_arb
  import bsg_mem_1rw_arb_pkg::*;
#(
  parameter int unsigned num_req_p     = 2,
  parameter int unsigned width_p       = 64,
  parameter int unsigned els_p         = 64,
  parameter int unsigned addr_width_lp = safe_clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [num_req_p-1:0]               w_i,
  input  logic [num_req_p*addr_width_lp-1:0] addr_i,
  input  logic [num_req_p*width_p-1:0]       data_i,
  input  logic [num_req_p*width_p-1:0]       w_mask_i,
  output logic [num_req_p-1:0]               ready_o,
  output logic [num_req_p-1:0]               v_o,
  output logic [num_req_p*width_p-1:0]       data_o,
  input  logic [num_req_p-1:0]               yumi_i,
  output logic                               init_done_o,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [addr_width_lp-1:0]           mem_addr_o,
  output logic [width_p-1:0]                 mem_data_o,
  output logic [width_p-1:0]                 mem_w_mask_o,
  input  logic [width_p-1:0]                 mem_data_i
);

  bsg_mem_1rw_arb_state_e state;

  logic [num_req_p-1:0] pending;
  logic [num_req_p-1:0] held;
  logic [num_req_p-1:0] outstanding;
  logic [num_req_p-1:0] eligible;
  logic [num_req_p-1:0] grant;
  logic                 arb_en;
  logic [width_p-1:0]   hold [num_req_p];

`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
  bsg_mem_1rw_arb_state_e   state_next;
  logic [addr_width_lp-1:0] clr_addr;
  logic [addr_width_lp-1:0] clr_addr_next;

  // Sequencer state and clear-sweep address register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= eInit;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // Sweep one address per cycle, leave eInit after the last one.
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      eInit: begin
        clr_addr_next = addr_width_lp'(clr_addr + addr_width_lp'(1));
        if (clr_addr == addr_width_lp'(els_p - 1)) begin
          state_next    = eReady;
          clr_addr_next = '0;
        end
      end
      eReady:  state_next = eReady;
      default: state_next = eInit;
    endcase
  end
`else
  assign state = eReady;
`endif

  assign init_done_o = (state == eReady);

  // A requester with a response still out may re-issue only while consuming it.
  assign outstanding = pending | held;
  assign eligible    = v_i & (~outstanding | yumi_i);
  assign arb_en      = ~reset_i & (state == eReady);

  bsg_mem_1rw_arb_rr #(
    .num_req_p(num_req_p)
  ) rr (
    .clk     (clk_i),
    .reset   (reset_i),
    .en      (arb_en),
    .eligible(eligible),
    .grant   (grant)
  );

  assign ready_o = grant;

  // Memory port: clear sweep, else the granted requester.
  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
    if (!reset_i && state == eInit) begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = clr_addr;
      mem_w_mask_o = '1;
    end
`endif
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant[i]) begin
        mem_v_o      = 1'b1;
        mem_w_o      = w_i[i];
        mem_addr_o   = addr_i[i*addr_width_lp +: addr_width_lp];
        mem_data_o   = data_i[i*width_p +: width_p];
        mem_w_mask_o = w_mask_i[i*width_p +: width_p];
      end
    end
  end

  // Response tracking: pending = data on mem_data_i now, held = data in hold reg.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending <= '0;
      held    <= '0;
      for (int unsigned i = 0; i < num_req_p; i++) hold[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (grant[i] && !w_i[i]) begin
          pending[i] <= 1'b1;
          held[i]    <= 1'b0;
        end else if (yumi_i[i]) begin
          pending[i] <= 1'b0;
          held[i]    <= 1'b0;
        end else if (pending[i]) begin
          pending[i] <= 1'b0;
          held[i]    <= 1'b1;
          hold[i]    <= mem_data_i;
        end
      end
    end
  end

  assign v_o = outstanding;

  // First response cycle bypasses the memory output; later cycles use hold.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (held[i])         data_o[i*width_p +: width_p] = hold[i];
      else if (pending[i]) data_o[i*width_p +: width_p] = mem_data_i;
    end
  end

  yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    ((yumi_i & ~v_o) == '0));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_arb.sv
module tb_bsg_mem_1rw_sync_mask_write_bit_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned E  = 64;
  localparam int unsigned AW = 6;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;
`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
  localparam logic clr_en = 1'b1;
`else
  localparam logic clr_en = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic [NR-1:0]     v_i, w_i, ready_o, v_o, yumi_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR*W-1:0]   data_i, w_mask_i, data_o;
  logic              init_done_o, mem_v_o, mem_w_o;
  logic [AW-1:0]     mem_addr_o;
  logic [W-1:0]      mem_data_o, mem_w_mask_o, mem_data_i;

  bsg_mem_1rw_sync_mask_write_bit_arb #(
    .num_req_p(NR), .width_p(W), .els_p(E)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .v_o(v_o),
    .data_o(data_o), .yumi_i(yumi_i), .init_done_o(init_done_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // Behavioural 1RW bit-masked memory, 1-cycle read latency.
  logic [W-1:0] mem [E] = '{default: '0};
  logic [W-1:0] mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) mem[mem_addr_o] <= (mem[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         mem_rdata <= mem[mem_addr_o];
    end
  end
  assign mem_data_i = mem_rdata;

  typedef struct {
    int unsigned   tag;
    logic [NR-1:0] ready;
    logic [NR-1:0] v;
    logic          mem_v;
    logic          mem_w;
    logic [AW-1:0] addr;
    logic          init_done;
    logic          d0;
    logic          wpay;
  } cyc_t;

  typedef struct {
    int           req;
    logic [W-1:0] data;
  } rsp_t;

  cyc_t        cyc_q[$];
  rsp_t        rsp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned tag_n = 0;
  logic        finish_req = 1'b0;

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_i    = '0;
    w_i    = '0;
    yumi_i = '0;
  endtask

  task automatic req(input int r, input logic w, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic [W-1:0] m);
    v_i[r]              = 1'b1;
    w_i[r]              = w;
    addr_i[r*AW +: AW]  = a;
    data_i[r*W +: W]    = d;
    w_mask_i[r*W +: W]  = m;
  endtask

  task automatic push_rsp(input int r, input logic [W-1:0] e);
    rsp_q.push_back('{req: r, data: e});
  endtask

  task automatic exp_cyc(input logic [NR-1:0] rdy, input logic [NR-1:0] v,
                         input logic mv, input logic mw, input logic [AW-1:0] a,
                         input logic id, input logic d0, input logic wp);
    cyc_q.push_back('{tag_n, rdy, v, mv, mw, a, id, d0, wp});
    tag_n++;
  endtask

`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
  task automatic sweep(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      idle();
      req(0, 1'b0, 6'd9, '0, '0);
      exp_cyc(4'b0000, 4'b0000, 1'b1, 1'b1, AW'(k), 1'b0, 1'b1, 1'b1);
    end
  endtask
`endif

  initial begin
    reset_i  = 1'b1;
    idle();
    addr_i   = '0;
    data_i   = '0;
    w_mask_i = '0;
    tick(); tick();
    exp_cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, ~clr_en, 1'b1, 1'b0);
    tick(); reset_i = 1'b0;
`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
    sweep(21);
    tick(); reset_i = 1'b1; idle();
    exp_cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick(); reset_i = 1'b0;
    sweep(64);
    tick(); idle();
`endif
    // first ready cycle: read R0 addr 9 (zero)
    req(0, 1'b0, 6'd9, '0, '0); push_rsp(0, 32'h0);
    exp_cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 6'd9, 1'b1, 1'b1, 1'b0);
    tick(); idle(); yumi_i[0] = 1'b1;
    exp_cyc(4'b0000, 4'b0001, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

    // masked writes then read back
    tick(); idle(); req(0, 1'b1, 6'd5, 32'hFFFF_0000, ONES);
    exp_cyc(4'b0001, 4'b0000, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0);
    tick(); idle(); req(1, 1'b1, 6'd5, 32'h0000_1234, 32'h0000_00FF);
    exp_cyc(4'b0010, 4'b0000, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0);
    tick(); idle(); req(0, 1'b0, 6'd5, '0, '0); push_rsp(0, 32'hFFFF_0034);
    exp_cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0);
    tick(); idle(); yumi_i[0] = 1'b1;
    exp_cyc(4'b0000, 4'b0001, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

    // all four request continuously; pointer is at 1 here
    for (int c = 0; c < 8; c++) begin
      tick(); idle();
      for (int r = 0; r < 4; r++) req(r, 1'b0, 6'd5, '0, '0);
      push_rsp((1 + c) % 4, 32'hFFFF_0034);
      if (c > 0) yumi_i[c % 4] = 1'b1;
      exp_cyc(4'(1 << ((1 + c) % 4)), (c > 0) ? 4'(1 << (c % 4)) : 4'b0000,
              1'b1, 1'b0, 6'd5, 1'b1, (c == 0), 1'b0);
    end
    tick(); idle(); yumi_i[0] = 1'b1;
    exp_cyc(4'b0000, 4'b0001, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

    // held response survives writes and other reads; R1 blocked until yumi
    tick(); idle(); req(2, 1'b1, 6'd7, 32'hAAAA_5555, ONES);
    exp_cyc(4'b0100, 4'b0000, 1'b1, 1'b1, 6'd7, 1'b1, 1'b1, 1'b0);
    tick(); idle(); req(1, 1'b0, 6'd7, '0, '0); push_rsp(1, 32'hAAAA_5555);
    exp_cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0);
    tick(); idle(); req(1, 1'b0, 6'd7, '0, '0); req(0, 1'b1, 6'd7, 32'h1111_1111, ONES);
    exp_cyc(4'b0001, 4'b0010, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
    tick(); idle(); req(1, 1'b0, 6'd7, '0, '0); req(0, 1'b0, 6'd9, '0, '0); push_rsp(0, 32'h0);
    exp_cyc(4'b0001, 4'b0010, 1'b1, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0);
    tick(); idle(); req(1, 1'b0, 6'd7, '0, '0); yumi_i[0] = 1'b1;
    exp_cyc(4'b0000, 4'b0011, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle(); req(1, 1'b0, 6'd7, '0, '0); yumi_i[1] = 1'b1; push_rsp(1, 32'h1111_1111);
    exp_cyc(4'b0010, 4'b0010, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0);
    tick(); idle(); yumi_i[1] = 1'b1;
    exp_cyc(4'b0000, 4'b0010, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

    // reset while a read is pending: response dropped, outputs cleared at once
    tick(); idle(); req(1, 1'b0, 6'd5, '0, '0);
    exp_cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0);
    tick(); reset_i = 1'b1; idle(); req(3, 1'b0, 6'd5, '0, '0);
    exp_cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, ~clr_en, 1'b1, 1'b0);
    tick(); idle();
    exp_cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, ~clr_en, 1'b1, 1'b0);
    tick(); reset_i = 1'b0; idle();
`ifdef BSG_MEM_1RW_ARB_CLEAR_ON_RESET_EN
    sweep(64);
    tick(); idle();
`endif
    // pointer restarted at 0: R1 beats R2
    req(1, 1'b0, 6'd9, '0, '0); req(2, 1'b0, 6'd9, '0, '0); push_rsp(1, 32'h0);
    exp_cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 6'd9, 1'b1, 1'b1, 1'b0);
    tick(); idle(); req(2, 1'b0, 6'd9, '0, '0); yumi_i[1] = 1'b1; push_rsp(2, 32'h0);
    exp_cyc(4'b0100, 4'b0010, 1'b1, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0);
    tick(); idle(); yumi_i[2] = 1'b1;
    exp_cyc(4'b0000, 4'b0100, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    exp_cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
    tick(); finish_req = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string nm, input int unsigned tag,
                     input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s tag=%0d got=%0h exp=%0h", nm, tag, got, exp);
    end
  endtask

  cyc_t mc;
  int   fidx;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      cmp("ready", mc.tag, 128'(ready_o), 128'(mc.ready));
      cmp("v_o", mc.tag, 128'(v_o), 128'(mc.v));
      cmp("mem_v", mc.tag, 128'(mem_v_o), 128'(mc.mem_v));
      cmp("init_done", mc.tag, 128'(init_done_o), 128'(mc.init_done));
      if (mc.mem_v) begin
        cmp("mem_w", mc.tag, 128'(mem_w_o), 128'(mc.mem_w));
        cmp("mem_addr", mc.tag, 128'(mem_addr_o), 128'(mc.addr));
      end
      if (mc.d0) cmp("data_zero", mc.tag, 128'(data_o), 128'(0));
      if (mc.wpay) begin
        cmp("clr_data", mc.tag, 128'(mem_data_o), 128'(0));
        cmp("clr_mask", mc.tag, 128'(mem_w_mask_o), 128'(ONES));
      end
    end
    for (int i = 0; i < int'(NR); i++) begin
      if (v_o[i]) begin
        fidx = -1;
        for (int k = 0; k < rsp_q.size(); k++)
          if (fidx < 0 && rsp_q[k].req == i) fidx = k;
        if (fidx < 0) begin
          cmp("rsp_unexpected", 32'(i), 128'(1), 128'(0));
        end else begin
          cmp("rsp_data", 32'(i), 128'(data_o[i*W +: W]), 128'(rsp_q[fidx].data));
          if (yumi_i[i]) rsp_q.delete(fidx);
        end
      end
    end
    if (finish_req) begin
      cmp("rsp_left", 0, 128'(rsp_q.size()), 128'(0));
      cmp("cyc_left", 0, 128'(cyc_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
